// File: rtl/multicycle_control_fsm_if.sv
// Unified memory port handshake between the multi-cycle control FSM (master) and memory (slave).
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WB strobes for the datapath.
// Optional perf counters enabled by defining RV_CTRL_PERF_CNT_EN.
module multicycle_control_fsm (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_control_fsm_if.master       mem,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic                           funct7_5,
  input  logic                           branch_cond,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           reg_write,
  output logic [1:0]                     alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [3:0]                     alu_ctrl,
  output logic [1:0]                     result_src,
  output logic [2:0]                     imm_src,
  output logic                           instr_done,
  output logic                           trap,
  output logic [31:0]                    cycle_count,
  output logic [31:0]                    instret_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_JAL_LINK, S_TRAP
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  state_e state_q, state_d;
  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s, instr_done_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
  logic [3:0] alu_ctrl_s;
  logic [2:0] imm_src_s;

  // Immediate-form ALU ops only honour funct7_5 for the arithmetic right shift.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7_5, input logic allow_sub);
    case (f3)
      3'b000:  alu_op = (allow_sub && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/qualified strobe decode.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_ctrl_s   = ALU_ADD;
    result_src_s = 2'b00;
    imm_src_s    = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        if (mem.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        imm_src_s   = IMM_B;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_LUI;
          OP_AUIPC:           state_d = S_AUIPC;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_s = 2'b10;
        alu_ctrl_s  = alu_op(funct3, funct7_5, 1'b1);
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_ctrl_s  = alu_op(funct3, funct7_5, 1'b0);
        state_d     = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a_s = 2'b11;
        alu_src_b_s = 2'b01;
        imm_src_s   = IMM_U;
        state_d     = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        imm_src_s   = IMM_U;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        imm_src_s   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d     = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        state_d   = mem.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        result_src_s = 2'b01;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_s    = 1'b1;
        mem_write_s  = 1'b1;
        adr_src_s    = 1'b1;
        instr_done_s = mem.mem_ready;
        state_d      = mem.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        alu_src_a_s  = 2'b10;
        alu_ctrl_s   = ALU_SUB;
        imm_src_s    = IMM_B;
        pc_write_s   = branch_cond;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a_s  = (state_q == S_JAL) ? 2'b01 : 2'b10;
        alu_src_b_s  = 2'b01;
        imm_src_s    = (state_q == S_JAL) ? IMM_J : IMM_I;
        pc_write_s   = 1'b1;
        result_src_s = 2'b10;
        state_d      = S_JAL_LINK;
      end
      S_JAL_LINK: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        reg_write_s  = 1'b1;
        result_src_s = 2'b10;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Every strobe is forced low while reset is held, even before the state register settles.
  assign mem.mem_req   = mem_req_s & reset;
  assign mem.mem_write = mem_write_s & reset;
  assign mem.adr_src   = adr_src_s & reset;
  assign ir_write      = ir_write_s & reset;
  assign pc_write      = pc_write_s & reset;
  assign reg_write     = reg_write_s & reset;
  assign instr_done    = instr_done_s & reset;
  assign alu_src_a     = alu_src_a_s & {2{reset}};
  assign alu_src_b     = alu_src_b_s & {2{reset}};
  assign alu_ctrl      = alu_ctrl_s & {4{reset}};
  assign result_src    = result_src_s & {2{reset}};
  assign imm_src       = imm_src_s & {3{reset}};
  assign trap          = (state_q == S_TRAP) & reset;

`ifdef RV_CTRL_PERF_CNT_EN
  logic [31:0] cycle_count_q, cycle_count_d, instret_count_q, instret_count_d;

  // Counter next values; the cycle counter freezes once trapped.
  always_comb begin
    cycle_count_d   = (state_q == S_TRAP) ? cycle_count_q : cycle_count_q + 32'd1;
    instret_count_d = instr_done_s ? instret_count_q + 32'd1 : instret_count_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count_q   <= 32'h0;
      instret_count_q <= 32'h0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
`else
  assign cycle_count   = 32'h0;
  assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction expectations from a class/latency model.
module tb_multicycle_control_fsm;
  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5, branch_cond;
  logic        ir_write, pc_write, reg_write, instr_done, trap;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_src;
  logic [31:0] cycle_count, instret_count;

  multicycle_control_fsm_if mem_if ();

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .mem(mem_if.master), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .branch_cond(branch_cond), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .imm_src(imm_src), .instr_done(instr_done), .trap(trap),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int exec_idx; int alu; int n_mreq; int n_mwr; int n_rw; int n_pcw; int rs; bit chk_rs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      K_R:     opc_of = 7'b0110011;
      K_I:     opc_of = 7'b0010011;
      K_LOAD:  opc_of = 7'b0000011;
      K_STORE: opc_of = 7'b0100011;
      K_BR:    opc_of = 7'b1100011;
      K_JAL:   opc_of = 7'b1101111;
      K_JALR:  opc_of = 7'b1100111;
      K_LUI:   opc_of = 7'b0110111;
      K_AUIPC: opc_of = 7'b0010111;
      default: opc_of = 7'h7F;
    endcase
  endfunction

  // ALU op expected during the execute step, from the opcode-class table.
  function automatic int exp_alu(input int k, input int f3, input bit f7);
    int tbl [8];
    tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (k == K_BR) return 1;
    if (k != K_R && k != K_I) return 0;
    if (f7 && f3 == 5) return 7;
    if (k == K_R && f7 && f3 == 0) return 1;
    return tbl[f3];
  endfunction

  // Push the expected retire record, then drive one instruction for its modelled latency.
  task automatic issue(input int k, input int f3, input bit f7, input bit bc, input int sf, input int sm_in);
    exp_t e;
    bit   is_mem;
    int   sm, base, m0;
    logic rdy;
    is_mem = (k == K_LOAD) || (k == K_STORE);
    sm     = is_mem ? sm_in : 0;
    case (k)
      K_LOAD:  base = 5;
      K_BR:    base = 3;
      default: base = 4;
    endcase
    e.lat      = base + sf + sm;
    e.exec_idx = sf + 2;
    e.alu      = exp_alu(k, f3, f7);
    e.n_mreq   = sf + 1 + (is_mem ? sm + 1 : 0);
    e.n_mwr    = (k == K_STORE) ? sm + 1 : 0;
    e.n_rw     = (k == K_STORE || k == K_BR) ? 0 : 1;
    e.n_pcw    = 1 + ((k == K_BR) ? int'(bc) : 0) + ((k == K_JAL || k == K_JALR) ? 1 : 0);
    e.chk_rs   = (k != K_STORE);
    e.rs       = (k == K_LOAD) ? 1 : ((k == K_JAL || k == K_JALR) ? 2 : 0);
    sb.push_back(e);
    opcode      = opc_of(k);
    funct3      = 3'(f3);
    funct7_5    = f7;
    branch_cond = bc;
    m0 = sf + 3;
    for (int c = 0; c < e.lat; c++) begin
      if (c < sf) rdy = 1'b0;
      else if (c == sf) rdy = 1'b1;
      else if (is_mem && c >= m0 && c < m0 + sm) rdy = 1'b0;
      else if (is_mem && c == m0 + sm) rdy = 1'b1;
      else rdy = 1'($urandom_range(0, 1));
      mem_if.mem_ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: accumulate per-instruction activity, compare against the scoreboard on retire.
  int         cyc = 0, m_mreq = 0, m_mwr = 0, m_rw = 0, m_pcw = 0, m_irw = 0;
  logic [3:0] alu_tr [64];
  exp_t       me;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      cyc = 0; m_mreq = 0; m_mwr = 0; m_rw = 0; m_pcw = 0; m_irw = 0;
    end else begin
      if (cyc < 64) alu_tr[cyc] = alu_ctrl;
      cyc++;
      if (mem_if.mem_req)   m_mreq++;
      if (mem_if.mem_write) m_mwr++;
      if (reg_write)        m_rw++;
      if (pc_write)         m_pcw++;
      if (ir_write)         m_irw++;
      if (instr_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
        end else begin
          me = sb.pop_front();
          check("latency", cyc, me.lat);
          check("exec_alu_ctrl", {28'd0, alu_tr[me.exec_idx]}, me.alu);
          check("mem_req_cycles", m_mreq, me.n_mreq);
          check("mem_write_cycles", m_mwr, me.n_mwr);
          check("reg_write_cycles", m_rw, me.n_rw);
          check("pc_write_cycles", m_pcw, me.n_pcw);
          check("ir_write_cycles", m_irw, 1);
          if (me.chk_rs) check("retire_result_src", {30'd0, result_src}, me.rs);
        end
        cyc = 0; m_mreq = 0; m_mwr = 0; m_rw = 0; m_pcw = 0; m_irw = 0;
      end
    end
  end

  // Stimulus: directed cases, random mix, mid-instruction reset, counters, trap.
  initial begin
    int k, f3;
    bit f7, bc;
    logic [31:0] exp_cyc, exp_ret;
    reset = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; branch_cond = 1'b0;
    mem_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_if.mem_req}, 0);
    check("rst_reg_write", {31'd0, reg_write}, 0);
    check("rst_pc_write", {31'd0, pc_write}, 0);
    check("rst_trap", {31'd0, trap}, 0);
    check("rst_cycle_count", cycle_count, 0);
    reset = 1'b1;
    #1;
    check("fetch_mem_req", {31'd0, mem_if.mem_req}, 1);
    check("fetch_alu_src_b", {30'd0, alu_src_b}, 2);
    check("fetch_result_src", {30'd0, result_src}, 2);

    issue(K_R, 0, 1'b0, 1'b0, 0, 0);
    issue(K_R, 0, 1'b1, 1'b0, 0, 0);
    issue(K_R, 5, 1'b1, 1'b0, 1, 0);
    issue(K_R, 3, 1'b0, 1'b0, 0, 0);
    issue(K_I, 5, 1'b1, 1'b0, 0, 0);
    issue(K_I, 5, 1'b0, 1'b0, 0, 0);
    issue(K_I, 0, 1'b1, 1'b0, 0, 0);
    issue(K_LOAD, 2, 1'b0, 1'b0, 0, 3);
    issue(K_STORE, 2, 1'b0, 1'b0, 0, 0);
    issue(K_STORE, 2, 1'b0, 1'b0, 2, 2);
    issue(K_BR, 0, 1'b0, 1'b1, 0, 0);
    issue(K_BR, 0, 1'b0, 1'b0, 0, 0);
    issue(K_JAL, 0, 1'b0, 1'b0, 0, 0);
    issue(K_JALR, 0, 1'b0, 1'b0, 1, 0);
    issue(K_LUI, 0, 1'b0, 1'b0, 0, 0);
    issue(K_AUIPC, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(0, 8));
      f3 = int'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      bc = 1'($urandom_range(0, 1));
      issue(k, f3, f7, bc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Load abandoned by reset while in its write-back cycle.
    opcode = opc_of(K_LOAD);
    mem_if.mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("memwb_reg_write", {31'd0, reg_write}, 1);
    reset = 1'b0;
    #1;
    check("abandon_reg_write", {31'd0, reg_write}, 0);
    check("abandon_instr_done", {31'd0, instr_done}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) issue(K_R, 0, 1'b0, 1'b0, 0, 0);
`ifdef RV_CTRL_PERF_CNT_EN
    exp_cyc = 32'd40; exp_ret = 32'd10;
`else
    exp_cyc = 32'd0;  exp_ret = 32'd0;
`endif
    check("cycle_count_10add", cycle_count, exp_cyc);
    check("instret_count_10add", instret_count, exp_ret);

    // Illegal opcode: FETCH, DECODE, then absorbing TRAP.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    opcode = 7'h7F;
    mem_if.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("trap_set", {31'd0, trap}, 1);
    check("trap_mem_req", {31'd0, mem_if.mem_req}, 0);
    check("trap_pc_write", {31'd0, pc_write}, 0);
    check("trap_ir_write", {31'd0, ir_write}, 0);
`ifdef RV_CTRL_PERF_CNT_EN
    exp_cyc = 32'd2;
`else
    exp_cyc = 32'd0;
`endif
    check("trap_cycle_count", cycle_count, exp_cyc);
    reset = 1'b0;
    #1;
    check("trap_in_reset", {31'd0, trap}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("trap_cleared", {31'd0, trap}, 0);
    check("post_trap_fetch", {31'd0, mem_if.mem_req}, 1);

    @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
